morse_key_decoder: RTL
======================

Name: morse_key_decoder

Overview:
- Receive-side counterpart of the morse LED blinker: the player keys morse on a push-button, and this block decodes what they send.
- It debounces the raw key and classifies each press as dot or dash by duration. It accumulates up to 5 symbols and, after a letter gap of silence, emits one decoded character code with a 1-cycle valid pulse.
- It sits between the front-panel key input and the puzzle-checking logic.

Parameters:
- DEBOUNCE, 500: cycles the synchronised key must be stable before key_db changes.
- MIN_PRESS, 2000: presses shorter than this (cycles) are discarded as glitches.
- DOT_MAX, 15000: longest press counted as a dot.
- DASH_MAX, 60000: longest press counted as a dash; longer holds are errors.
- LETTER_GAP, 30000: key-up cycles that terminate a letter.
- CW, 32: width of the duration counter.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-low.
- enable, input, 1: decoder active; low forces IDLE and clears the symbol buffer.
- key, input, 1: raw button, active-high, asynchronous.
- key_led, output, 1: registered echo of key_db, for operator feedback.
- char_valid, output, 1: 1-cycle pulse; char is valid.
- char, output, 6: 1–26 = A–Z, 27–36 = digits 0–9; held until the next char_valid.
- pattern, output, 5: symbol shift register; last symbol in bit 0; 1 = dash.
- sym_count, output, 3: number of symbols captured in the current letter (0–5).
- error, output, 1: 1-cycle pulse on a decode or timing error.

Behaviour:
- Reset (reset=0 at clk edge):
  - state=IDLE, counter=0, pattern=0, sym_count=0.
  - char=0, char_valid=0, error=0, key_led=0, key_db=0.
  - The 2-FF synchroniser and debounce counter are cleared.
  - Reset mid-letter discards the partial letter with no pulse.
- Input path:
  - key passes through a 2-FF synchroniser, then a debounce counter.
  - key_db takes the synchronised value after DEBOUNCE consecutive equal cycles.
  - Latency from raw key to key_db is DEBOUNCE+2 cycles.
- enable=0: state goes to IDLE, pattern and sym_count are cleared, and no pulses are produced. The debounce logic keeps running.
- IDLE:
  - key_db=1 → PRESS, counter=1.
- PRESS:
  - Each cycle with key_db=1, counter increments.
  - When counter reaches DASH_MAX+1 → ERR_WAIT, error pulse.
  - On the first cycle with key_db=0, classify the press:
    - counter<MIN_PRESS: discard; go to GAP if sym_count>0, otherwise IDLE.
    - MIN_PRESS≤counter≤DOT_MAX: dot. pattern={pattern[3:0],0}, sym_count++.
    - DOT_MAX<counter≤DASH_MAX: dash. pattern={pattern[3:0],1}, sym_count++.
  - After a dot or dash: if sym_count was already 5 → ERR_WAIT with error pulse; otherwise → GAP with counter=1.
- GAP:
  - key_db=0: counter increments.
  - key_db=1 before counter reaches LETTER_GAP → PRESS, counter=1.
  - counter==LETTER_GAP → EMIT.
- EMIT (1 cycle):
  - Look up (sym_count, pattern) in the standard ITU table.
  - On a hit: char=code, char_valid=1.
  - On a miss: error=1, char unchanged.
  - Then pattern=0, sym_count=0 → IDLE.
- ERR_WAIT:
  - Clear pattern and sym_count on entry.
  - Wait for key_db=0 held continuously for LETTER_GAP cycles → IDLE. Any press restarts the wait.
- Pulse rules:
  - char_valid and error are never asserted in the same cycle.
  - Each pulse lasts exactly 1 cycle.
  - char_valid rises the cycle after the GAP counter equals LETTER_GAP.
- Counter: saturates at its terminal value and never wraps.
- Simultaneous events: if enable falls in the EMIT cycle, the pulse is suppressed.

Test Plan:
All scenarios use overrides DEBOUNCE=2, MIN_PRESS=4, DOT_MAX=10, DASH_MAX=30, LETTER_GAP=20.
- Press 6 cycles, release 8, press 20, release ≥30 → one char_valid, char=1 (A), pattern=00001, sym_count=2 before clear.
- Five 20-cycle presses separated by 8-cycle gaps, then silence → char=27 (digit 0); a sixth press at the same spacing instead gives an error pulse and no char_valid.
- 3-cycle press only → no pulse; state returns to IDLE; sym_count stays 0.
- Hold key 40 cycles → error pulse when counter reaches 31. No further pulses until the key has been released for 20 debounced cycles; then an "E" (single 6-cycle press) decodes to char=5.
- Pattern dot-dot-dash-dash (not in table) → error pulse, char holds its prior value.
- 1-cycle key glitches → key_db and key_led unchanged. Reset asserted mid-GAP after one dot → no pulse, sym_count=0 the next cycle. enable dropped mid-letter → no pulse.

Source files
------------

// File: rtl/morse_key_decoder.sv
// morse_key_decoder
//   Decodes morse keyed on a push-button. The raw key is synchronised and
//   debounced, each press is classified as dot or dash by its length, and
//   after a letter gap of silence the accumulated symbols are looked up in
//   the ITU table and emitted as a character code with a 1-cycle pulse.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-low
//   enable     decoder active; low forces IDLE and clears the symbol buffer
//   key        raw button, active-high, asynchronous
//   key_led    registered echo of the debounced key
//   char_valid 1-cycle pulse, char is valid
//   char       1-26 = A-Z, 27-36 = digits 0-9; held until next char_valid
//   pattern    symbol shift register, last symbol in bit 0, 1 = dash
//   sym_count  symbols captured in the current letter (0-5)
//   error      1-cycle pulse on a decode or timing error
module morse_key_decoder #(
    parameter int DEBOUNCE   = 500,
    parameter int MIN_PRESS  = 2000,
    parameter int DOT_MAX    = 15000,
    parameter int DASH_MAX   = 60000,
    parameter int LETTER_GAP = 30000,
    parameter int CW         = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       key,
    output logic       key_led,
    output logic       char_valid,
    output logic [5:0] char,
    output logic [4:0] pattern,
    output logic [2:0] sym_count,
    output logic       error
);

    localparam int DB_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [CW-1:0]   ONE      = CW'(1);
    localparam logic [CW-1:0]   MIN_C    = CW'(MIN_PRESS);
    localparam logic [CW-1:0]   DOT_C    = CW'(DOT_MAX);
    localparam logic [CW-1:0]   DASH_C   = CW'(DASH_MAX);
    localparam logic [CW-1:0]   GAP_C    = CW'(LETTER_GAP);
    localparam logic [CW-1:0]   ERR_LAST = CW'(LETTER_GAP - 1);

    typedef enum logic [2:0] {
        IDLE, PRESS, GAP, EMIT, ERR_WAIT
    } state_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic            sync1, sync2, key_db;
    logic [DB_W-1:0] db_cnt;
    logic [5:0]      emit_code;

    // ITU lookup keyed on {symbol count, pattern}; 0 means no such letter.
    function automatic logic [5:0] morse_lookup(input logic [2:0] n, input logic [4:0] p);
        logic [5:0] code;
        code = 6'd0;
        case ({n, p})
            {3'd2, 5'b00001}: code = 6'd1;   // A .-
            {3'd4, 5'b01000}: code = 6'd2;   // B -...
            {3'd4, 5'b01010}: code = 6'd3;   // C -.-.
            {3'd3, 5'b00100}: code = 6'd4;   // D -..
            {3'd1, 5'b00000}: code = 6'd5;   // E .
            {3'd4, 5'b00010}: code = 6'd6;   // F ..-.
            {3'd3, 5'b00110}: code = 6'd7;   // G --.
            {3'd4, 5'b00000}: code = 6'd8;   // H ....
            {3'd2, 5'b00000}: code = 6'd9;   // I ..
            {3'd4, 5'b00111}: code = 6'd10;  // J .---
            {3'd3, 5'b00101}: code = 6'd11;  // K -.-
            {3'd4, 5'b00100}: code = 6'd12;  // L .-..
            {3'd2, 5'b00011}: code = 6'd13;  // M --
            {3'd2, 5'b00010}: code = 6'd14;  // N -.
            {3'd3, 5'b00111}: code = 6'd15;  // O ---
            {3'd4, 5'b00110}: code = 6'd16;  // P .--.
            {3'd4, 5'b01101}: code = 6'd17;  // Q --.-
            {3'd3, 5'b00010}: code = 6'd18;  // R .-.
            {3'd3, 5'b00000}: code = 6'd19;  // S ...
            {3'd1, 5'b00001}: code = 6'd20;  // T -
            {3'd3, 5'b00001}: code = 6'd21;  // U ..-
            {3'd4, 5'b00001}: code = 6'd22;  // V ...-
            {3'd3, 5'b00011}: code = 6'd23;  // W .--
            {3'd4, 5'b01001}: code = 6'd24;  // X -..-
            {3'd4, 5'b01011}: code = 6'd25;  // Y -.--
            {3'd4, 5'b01100}: code = 6'd26;  // Z --..
            {3'd5, 5'b11111}: code = 6'd27;  // 0 -----
            {3'd5, 5'b01111}: code = 6'd28;  // 1 .----
            {3'd5, 5'b00111}: code = 6'd29;  // 2 ..---
            {3'd5, 5'b00011}: code = 6'd30;  // 3 ...--
            {3'd5, 5'b00001}: code = 6'd31;  // 4 ....-
            {3'd5, 5'b00000}: code = 6'd32;  // 5 .....
            {3'd5, 5'b10000}: code = 6'd33;  // 6 -....
            {3'd5, 5'b11000}: code = 6'd34;  // 7 --...
            {3'd5, 5'b11100}: code = 6'd35;  // 8 ---..
            {3'd5, 5'b11110}: code = 6'd36;  // 9 ----.
            default:          code = 6'd0;
        endcase
        return code;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == {CW{1'b1}}) ? c : c + ONE;
    endfunction

    assign emit_code = morse_lookup(sym_count, pattern);

    // Synchroniser + debounce: key_db follows sync2 once it has differed
    // for DEBOUNCE consecutive cycles (raw-to-key_db latency DEBOUNCE+2).
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            key_db  <= 1'b0;
            db_cnt  <= '0;
            key_led <= 1'b0;
        end else begin
            sync1   <= key;
            sync2   <= sync1;
            key_led <= key_db;
            if (sync2 == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                key_db <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            counter    <= '0;
            pattern    <= '0;
            sym_count  <= '0;
            char       <= '0;
            char_valid <= 1'b0;
            error      <= 1'b0;
        end else begin
            char_valid <= 1'b0;
            error      <= 1'b0;
            if (!enable) begin
                state     <= IDLE;
                counter   <= '0;
                pattern   <= '0;
                sym_count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (key_db) begin
                            state   <= PRESS;
                            counter <= ONE;
                        end
                    end
                    PRESS: begin
                        if (key_db) begin
                            // Next held cycle would be DASH_MAX+1: too long.
                            if (counter >= DASH_C) begin
                                state     <= ERR_WAIT;
                                error     <= 1'b1;
                                counter   <= '0;
                                pattern   <= '0;
                                sym_count <= '0;
                            end else begin
                                counter <= sat_inc(counter);
                            end
                        end else if (counter < MIN_C) begin
                            // Glitch press: ignore, restart any letter gap.
                            state   <= (sym_count != 3'd0) ? GAP : IDLE;
                            counter <= ONE;
                        end else if (sym_count == 3'd5) begin
                            // A sixth symbol cannot be any character.
                            state     <= ERR_WAIT;
                            error     <= 1'b1;
                            counter   <= '0;
                            pattern   <= '0;
                            sym_count <= '0;
                        end else begin
                            pattern   <= {pattern[3:0], (counter > DOT_C)};
                            sym_count <= sym_count + 3'd1;
                            state     <= GAP;
                            counter   <= ONE;
                        end
                    end
                    GAP: begin
                        if (key_db) begin
                            state   <= PRESS;
                            counter <= ONE;
                        end else if (counter >= GAP_C) begin
                            state <= EMIT;
                        end else begin
                            counter <= sat_inc(counter);
                        end
                    end
                    EMIT: begin
                        if (emit_code != 6'd0) begin
                            char       <= emit_code;
                            char_valid <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                        pattern   <= '0;
                        sym_count <= '0;
                        counter   <= '0;
                        state     <= IDLE;
                    end
                    ERR_WAIT: begin
                        // Needs LETTER_GAP continuous key-up cycles.
                        if (key_db) begin
                            counter <= '0;
                        end else if (counter >= ERR_LAST) begin
                            counter <= '0;
                            state   <= IDLE;
                        end else begin
                            counter <= sat_inc(counter);
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        counter <= '0;
                    end
                endcase
            end
        end
    end

endmodule
